// File: rtl/pe_pkg.sv
// Shared widths, FSM states and the peak record used by peak_select.
package pe_pkg;

  localparam int unsigned PE_FREQ_W  = 11;
  localparam int unsigned PE_MAG_W   = 32;
  localparam int unsigned PE_PHASE_W = 16;
  localparam int unsigned PE_CNT_W   = 4;
  localparam int unsigned PE_K_MAX   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } pe_state_e;

  typedef struct packed {
    logic [PE_FREQ_W-1:0]  freq;
    logic [PE_MAG_W-1:0]   mag;
    logic [PE_PHASE_W-1:0] dphase;
  } peak_t;

  // Phase difference with natural two's-complement wrap.
  function automatic logic [PE_PHASE_W-1:0] phase_diff(input logic [PE_PHASE_W-1:0] a,
                                                       input logic [PE_PHASE_W-1:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/peak_insert.sv
// Sorted K-entry peak list (descending magnitude), one insertion per cycle.
module peak_insert
  import pe_pkg::*;
#(
  parameter int unsigned           K       = 4,
  parameter logic [PE_MAG_W-1:0]   MIN_MAG = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ins_valid,
  input  logic                 ins_restart,
  input  peak_t                ins_peak,
  output peak_t [K-1:0]        list_o,
  output logic [PE_CNT_W-1:0]  count_o
);

  peak_t [K-1:0]        list_q, list_d;
  logic [PE_CNT_W-1:0]  count_q, count_d;

  peak_t [K-1:0]        base_list;
  logic [PE_CNT_W-1:0]  base_count;
  logic [K-1:0]         gt;
  logic                 mag_ok;
  logic                 accept;

  // A zero threshold admits everything; avoid a constant unsigned compare.
  if (MIN_MAG == '0) begin : g_no_min
    assign mag_ok = 1'b1;
  end else begin : g_min
    assign mag_ok = (ins_peak.mag >= MIN_MAG);
  end

  // Compare against every slot and shift the tail down below the insertion point.
  always_comb begin
    list_d     = list_q;
    count_d    = count_q;
    base_list  = ins_restart ? '0 : list_q;
    base_count = ins_restart ? '0 : count_q;
    gt         = '0;

    // gt[i]: new beat belongs at or above slot i; strict > keeps earlier ties higher.
    for (int i = 0; i < K; i++) begin
      gt[i] = (PE_CNT_W'(i) >= base_count) || (ins_peak.mag > base_list[i].mag);
    end

    accept = ins_valid && mag_ok && gt[K-1];

    if (ins_valid && ins_restart) begin
      list_d  = '0;
      count_d = '0;
    end

    if (accept) begin
      list_d[0] = gt[0] ? ins_peak : base_list[0];
      for (int i = 1; i < K; i++) begin
        if (gt[i]) begin
          list_d[i] = gt[i-1] ? base_list[i-1] : ins_peak;
        end else begin
          list_d[i] = base_list[i];
        end
      end
      count_d = (base_count < PE_CNT_W'(K)) ? base_count + PE_CNT_W'(1) : base_count;
    end
  end

  // List and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      list_q  <= '0;
      count_q <= '0;
    end else begin
      list_q  <= list_d;
      count_q <= count_d;
    end
  end

  assign list_o  = list_q;
  assign count_o = count_q;

endmodule

// File: rtl/peak_select.sv
// Keeps the K strongest bins of each frame and replays them as a result frame.
module peak_select
  import pe_pkg::*;
#(
  parameter int unsigned           FREQ_WIDTH  = PE_FREQ_W,
  parameter int unsigned           MAG_WIDTH   = PE_MAG_W,
  parameter int unsigned           PHASE_WIDTH = PE_PHASE_W,
  parameter int unsigned           K           = 4,
  parameter logic [MAG_WIDTH-1:0]  MIN_MAG     = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sink_sop,
  input  logic                    sink_eop,
  input  logic                    sink_valid,
  input  logic [FREQ_WIDTH-1:0]   sink_freq,
  input  logic [MAG_WIDTH-1:0]    sink_mag,
  input  logic [PHASE_WIDTH-1:0]  sink_phaseA,
  input  logic [PHASE_WIDTH-1:0]  sink_phaseB,
  output logic                    source_sop,
  output logic                    source_eop,
  output logic                    source_valid,
  output logic [FREQ_WIDTH-1:0]   source_freq,
  output logic [MAG_WIDTH-1:0]    source_mag,
  output logic [PHASE_WIDTH-1:0]  source_dphase,
  output logic [3:0]              source_count,
  output logic                    frame_error
);

  // Stored records use the package widths; the port parameters are expected to match them.
  pe_state_e               state_q, state_d;
  logic [PE_CNT_W-1:0]     idx_q, idx_d;

  logic                    sop_q, sop_d;
  logic                    eop_q, eop_d;
  logic                    valid_q, valid_d;
  logic [FREQ_WIDTH-1:0]   freq_q, freq_d;
  logic [MAG_WIDTH-1:0]    mag_q, mag_d;
  logic [PHASE_WIDTH-1:0]  dphase_q, dphase_d;
  logic [3:0]              count_q, count_d;
  logic                    err_q, err_d;

  logic                    ins_valid;
  logic                    ins_restart;
  peak_t                   ins_peak;
  peak_t [K-1:0]           list;
  logic [PE_CNT_W-1:0]     list_count;
  peak_t                   sel;

  // Beat-to-record conversion; dphase is fixed at insertion time.
  always_comb begin
    ins_peak.freq   = PE_FREQ_W'(sink_freq);
    ins_peak.mag    = PE_MAG_W'(sink_mag);
    ins_peak.dphase = phase_diff(PE_PHASE_W'(sink_phaseA), PE_PHASE_W'(sink_phaseB));
  end

  peak_insert #(
    .K       (K),
    .MIN_MAG (PE_MAG_W'(MIN_MAG))
  ) u_insert (
    .clk         (clk),
    .reset       (reset),
    .ins_valid   (ins_valid),
    .ins_restart (ins_restart),
    .ins_peak    (ins_peak),
    .list_o      (list),
    .count_o     (list_count)
  );

  // Entry currently being replayed.
  always_comb begin
    sel = '0;
    for (int i = 0; i < K; i++) begin
      if (idx_q == PE_CNT_W'(i)) sel = list[i];
    end
  end

  // Next-state, list control and registered-output values.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ins_valid   = 1'b0;
    ins_restart = 1'b0;
    err_d       = 1'b0;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    valid_d     = 1'b0;
    freq_d      = '0;
    mag_d       = '0;
    dphase_d    = '0;
    count_d     = '0;

    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (sink_valid) begin
          if (sink_sop) begin
            ins_valid   = 1'b1;
            ins_restart = 1'b1;
            state_d     = sink_eop ? EMIT : COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      COLLECT: begin
        idx_d = '0;
        if (sink_valid) begin
          ins_valid = 1'b1;
          if (sink_sop) begin
            ins_restart = 1'b1;
            err_d       = 1'b1;
          end
          if (sink_eop) state_d = EMIT;
        end
      end

      EMIT: begin
        if (sink_valid) err_d = 1'b1;
        if (list_count == '0) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          valid_d  = 1'b1;
          freq_d   = FREQ_WIDTH'(sel.freq);
          mag_d    = MAG_WIDTH'(sel.mag);
          dphase_d = PHASE_WIDTH'(sel.dphase);
          count_d  = 4'(list_count);
          sop_d    = (idx_q == '0);
          eop_d    = (idx_q == list_count - PE_CNT_W'(1));
          if (eop_d) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + PE_CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      valid_q  <= 1'b0;
      freq_q   <= '0;
      mag_q    <= '0;
      dphase_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      valid_q  <= valid_d;
      freq_q   <= freq_d;
      mag_q    <= mag_d;
      dphase_q <= dphase_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign source_sop    = sop_q;
  assign source_eop    = eop_q;
  assign source_valid  = valid_q;
  assign source_freq   = freq_q;
  assign source_mag    = mag_q;
  assign source_dphase = dphase_q;
  assign source_count  = count_q;
  assign frame_error   = err_q;

endmodule

// File: tb/tb_peak_select.sv
// Directed bench for peak_select: default instance plus a MIN_MAG=50 instance.
module tb_peak_select;

  localparam int unsigned FW = 11;
  localparam int unsigned MW = 32;
  localparam int unsigned PW = 16;

  logic          clk;
  logic          reset;
  logic          sink_sop, sink_eop, sink_valid;
  logic [FW-1:0] sink_freq;
  logic [MW-1:0] sink_mag;
  logic [PW-1:0] sink_pa, sink_pb;

  logic          src_sop, src_eop, src_valid, frame_error;
  logic [FW-1:0] src_freq;
  logic [MW-1:0] src_mag;
  logic [PW-1:0] src_dphase;
  logic [3:0]    src_count;

  logic          m_sop, m_eop, m_valid, m_frame_error;
  logic [FW-1:0] m_freq;
  logic [MW-1:0] m_mag;
  logic [PW-1:0] m_dphase;
  logic [3:0]    m_count;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [FW-1:0] freq;
    logic [MW-1:0] mag;
    logic [PW-1:0] dph;
    logic [3:0]    cnt;
  } beat_t;

  beat_t q[$];
  beat_t mq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    err_hi = 0;
  int    m_err_hi = 0;

  peak_select dut (
    .clk(clk), .reset(reset),
    .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_valid(sink_valid),
    .sink_freq(sink_freq), .sink_mag(sink_mag),
    .sink_phaseA(sink_pa), .sink_phaseB(sink_pb),
    .source_sop(src_sop), .source_eop(src_eop), .source_valid(src_valid),
    .source_freq(src_freq), .source_mag(src_mag), .source_dphase(src_dphase),
    .source_count(src_count), .frame_error(frame_error)
  );

  peak_select #(.MIN_MAG(32'd50)) dut_m (
    .clk(clk), .reset(reset),
    .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_valid(sink_valid),
    .sink_freq(sink_freq), .sink_mag(sink_mag),
    .sink_phaseA(sink_pa), .sink_phaseB(sink_pb),
    .source_sop(m_sop), .source_eop(m_eop), .source_valid(m_valid),
    .source_freq(m_freq), .source_mag(m_mag), .source_dphase(m_dphase),
    .source_count(m_count), .frame_error(m_frame_error)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Record output beats and error pulses on the falling edge.
  always @(negedge clk) begin
    if (src_valid) q.push_back({src_sop, src_eop, src_freq, src_mag, src_dphase, src_count});
    else check_val("idle_zero", 64'({src_freq, src_mag, src_dphase}), 64'd0);
    if (m_valid) mq.push_back({m_sop, m_eop, m_freq, m_mag, m_dphase, m_count});
    if (frame_error) err_hi++;
    if (m_frame_error) m_err_hi++;
  end

  task automatic drive(input logic sop, input logic eop, input logic [FW-1:0] f,
                       input logic [MW-1:0] m, input logic [PW-1:0] a, input logic [PW-1:0] b);
    sink_valid = 1'b1; sink_sop = sop; sink_eop = eop;
    sink_freq = f; sink_mag = m; sink_pa = a; sink_pb = b;
    @(posedge clk); #1;
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    sink_freq = '0; sink_mag = '0; sink_pa = '0; sink_pb = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_beat(input string tag, input beat_t b, input logic sop, input logic eop,
                            input int f, input int m, input int d, input int c);
    check_val({tag, "_sop"},  64'(b.sop),  64'(sop));
    check_val({tag, "_eop"},  64'(b.eop),  64'(eop));
    check_val({tag, "_freq"}, 64'(b.freq), 64'(f));
    check_val({tag, "_mag"},  64'(b.mag),  64'(m));
    check_val({tag, "_dph"},  64'(b.dph),  64'(d));
    check_val({tag, "_cnt"},  64'(b.cnt),  64'(c));
  endtask

  int mags1 [8] = '{5, 90, 3, 70, 90, 1, 40, 2};
  int exp_f1[4] = '{1, 4, 3, 6};
  int exp_m1[4] = '{90, 90, 70, 40};
  int e0;

  initial begin
    reset = 1'b1;
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    sink_freq = '0; sink_mag = '0; sink_pa = '0; sink_pb = '0;
    #15;
    check_val("rst_valid", 64'(src_valid), 64'd0);
    check_val("rst_sop",   64'(src_sop),   64'd0);
    check_val("rst_eop",   64'(src_eop),   64'd0);
    check_val("rst_count", 64'(src_count), 64'd0);
    check_val("rst_err",   64'(frame_error), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    // 8-bin frame: top four with tie order and two-cycle latency.
    q.delete();
    for (int i = 0; i < 8; i++)
      drive(i == 0, i == 7, FW'(i), MW'(mags1[i]), PW'(16'h1000 + i), 16'h0010);
    check_val("s1_lat_pre", 64'(src_valid), 64'd0);
    idle(1);
    check_val("s1_lat_first", 64'(src_valid), 64'd1);
    check_val("s1_lat_sop",   64'(src_sop),   64'd1);
    idle(6);
    check_val("s1_n", 64'(q.size()), 64'd4);
    if (q.size() == 4)
      for (int i = 0; i < 4; i++)
        check_beat($sformatf("s1_b%0d", i), q[i], i == 0, i == 3,
                   exp_f1[i], exp_m1[i], 32'h0FF0 + exp_f1[i], 4);

    // Single sop+eop beat with wrapping phase difference.
    q.delete();
    drive(1'b1, 1'b1, 11'd5, 32'd10, 16'h7000, 16'h9000);
    idle(5);
    check_val("s2_n", 64'(q.size()), 64'd1);
    if (q.size() == 1) check_beat("s2_b0", q[0], 1'b1, 1'b1, 5, 10, 32'hE000, 1);

    // MIN_MAG=50 instance: sub-threshold frame emits nothing, IDLE one cycle after EMIT.
    mq.delete();
    e0 = m_err_hi;
    drive(1'b1, 1'b0, 11'd1, 32'd10, '0, '0);
    drive(1'b0, 1'b0, 11'd2, 32'd49, '0, '0);
    drive(1'b0, 1'b1, 11'd3, 32'd20, '0, '0);
    idle(1);
    drive(1'b1, 1'b1, 11'd4, 32'd60, 16'h0005, 16'h0001);
    idle(6);
    check_val("s3_err", 64'(m_err_hi - e0), 64'd0);
    check_val("s3_n", 64'(mq.size()), 64'd1);
    if (mq.size() == 1) check_beat("s3_b0", mq[0], 1'b1, 1'b1, 4, 60, 4, 1);
    idle(8);

    // Second sop mid-frame restarts collection.
    q.delete();
    e0 = err_hi;
    drive(1'b1, 1'b0, 11'd20, 32'd100, '0, '0);
    drive(1'b0, 1'b0, 11'd21, 32'd200, '0, '0);
    drive(1'b0, 1'b0, 11'd22, 32'd300, '0, '0);
    drive(1'b1, 1'b0, 11'd10, 32'd7,   '0, '0);
    drive(1'b0, 1'b1, 11'd11, 32'd8,   '0, '0);
    idle(6);
    check_val("s4_err", 64'(err_hi - e0), 64'd1);
    check_val("s4_n", 64'(q.size()), 64'd2);
    if (q.size() == 2) begin
      check_beat("s4_b0", q[0], 1'b1, 1'b0, 11, 8, 0, 2);
      check_beat("s4_b1", q[1], 1'b0, 1'b1, 10, 7, 0, 2);
    end

    // Reset during EMIT after two beats.
    q.delete();
    drive(1'b1, 1'b0, 11'd0, 32'd40, '0, '0);
    drive(1'b0, 1'b0, 11'd1, 32'd30, '0, '0);
    drive(1'b0, 1'b0, 11'd2, 32'd20, '0, '0);
    drive(1'b0, 1'b1, 11'd3, 32'd10, '0, '0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check_val("s5_valid", 64'(src_valid), 64'd0);
    check_val("s5_eop",   64'(src_eop),   64'd0);
    check_val("s5_mag",   64'(src_mag),   64'd0);
    check_val("s5_count", 64'(src_count), 64'd0);
    idle(2);
    reset = 1'b0;
    idle(6);
    check_val("s5_n", 64'(q.size()), 64'd2);
    if (q.size() == 2) begin
      check_beat("s5_b0", q[0], 1'b1, 1'b0, 0, 40, 0, 4);
      check_beat("s5_b1", q[1], 1'b0, 1'b0, 1, 30, 0, 4);
    end
    q.delete();
    e0 = err_hi;
    drive(1'b1, 1'b0, 11'd7, 32'd3, '0, '0);
    drive(1'b0, 1'b1, 11'd8, 32'd9, '0, '0);
    idle(6);
    check_val("s5_post_err", 64'(err_hi - e0), 64'd0);
    check_val("s5_post_n", 64'(q.size()), 64'd2);
    if (q.size() == 2) begin
      check_beat("s5_post_b0", q[0], 1'b1, 1'b0, 8, 9, 0, 2);
      check_beat("s5_post_b1", q[1], 1'b0, 1'b1, 7, 3, 0, 2);
    end

    // Valid beat without sop while IDLE.
    q.delete();
    e0 = err_hi;
    drive(1'b0, 1'b0, 11'd3, 32'd77, '0, '0);
    idle(6);
    check_val("s6_err", 64'(err_hi - e0), 64'd1);
    check_val("s6_n", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/peak_select.md
PEAK_SELECT -- requirements
Module: peak_select

Interface
REQ-001 Parameter FREQ_WIDTH, default 11; width of the bin index.
REQ-002 Parameter MAG_WIDTH, default 32; width of the unsigned magnitude.
REQ-003 Parameter PHASE_WIDTH, default 16; width of the two's-complement phase, full scale = [-pi, pi).
REQ-004 Parameter K, default 4, range 1..8; number of peaks retained per frame.
REQ-005 Parameter MIN_MAG, default 0; magnitudes below this value are discarded.
REQ-006 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock, 50 MHz; all logic rising-edge.
- reset  in  1  asynchronous, active-high.
- sink_sop  in  1  first bin of a frame.
- sink_eop  in  1  last bin of a frame.
- sink_valid  in  1  bin beat qualifier.
- sink_freq  in  FREQ_WIDTH  bin index.
- sink_mag  in  MAG_WIDTH  bin magnitude.
- sink_phaseA  in  PHASE_WIDTH  channel A phase.
- sink_phaseB  in  PHASE_WIDTH  channel B phase.
- source_sop  out  1  first peak of a result frame.
- source_eop  out  1  last peak of a result frame.
- source_valid  out  1  peak beat qualifier.
- source_freq  out  FREQ_WIDTH  peak bin index.
- source_mag  out  MAG_WIDTH  peak magnitude.
- source_dphase  out  PHASE_WIDTH  phaseA minus phaseB.
- source_count  out  4  number of peaks in the current result frame, held during EMIT.
- frame_error  out  1  one-cycle pulse on a framing violation.

Function
REQ-007 The FSM SHALL have three states: IDLE, COLLECT, EMIT.
REQ-008 IDLE: a beat with sink_valid=1 and sink_sop=1 SHALL clear the list, insert the beat, and go to COLLECT; if sink_eop=1 is also set, go to EMIT instead.
REQ-009 IDLE: a valid beat with sop=0 SHALL be ignored and pulse frame_error.
REQ-010 COLLECT: each valid beat SHALL be inserted; a beat with eop=1 is inserted, then the FSM goes to EMIT.
REQ-011 COLLECT: a valid beat with sop=1 SHALL discard the list, pulse frame_error, and restart collection with that beat.
REQ-012 Insertion SHALL keep the list sorted by descending magnitude in one cycle per beat.
- A beat enters only if mag >= MIN_MAG and mag > the smallest held entry, or the list is not full.
- On equal magnitudes, the earlier-arriving beat ranks higher.
- When the list is full, the lowest entry is dropped.
REQ-013 dphase SHALL be computed at insertion as (phaseA - phaseB) mod 2^PHASE_WIDTH, with natural wrap and no saturation.
REQ-014 EMIT: entries 0..count-1 SHALL be output one per cycle with source_valid=1.
- source_sop is set with entry 0; source_eop is set with entry count-1.
- The first beat appears 2 cycles after the sink eop beat.
REQ-015 EMIT with count=0 SHALL output nothing and return to IDLE after 1 cycle.
REQ-016 Sink beats arriving during EMIT SHALL be ignored and pulse frame_error; the FSM returns to IDLE after the last beat.
REQ-017 When source_valid=0, source_freq, source_mag and source_dphase SHALL be 0.

Reset
REQ-018 Asserting reset SHALL immediately force the FSM to IDLE.
- All outputs go to 0, the list is cleared, and count goes to 0.
- This includes assertion in the middle of a frame or during EMIT; no partial result is emitted.
REQ-019 After reset is released, the first accepted beat SHALL be a valid sop beat.

Structure
REQ-020 Package pe_pkg SHALL hold the width constants, the state enum (IDLE/COLLECT/EMIT), and the peak_t struct {freq, mag, dphase}.
REQ-021 The sorted K-entry register list with compare-and-shift SHALL be the sub-module peak_insert; FSM and output muxing stay in peak_select.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- 8-bin frame, mags 5,90,3,70,90,1,40,2 at freq 0..7 -> out freq 1,4,3,6; mags 90,90,70,40; sop on freq 1; eop on freq 6; count=4.
- Single beat with sop=eop=1, mag 10, phaseA=0x7000, phaseB=0x9000 -> one beat with sop=eop=1 and dphase=0xE000.
- MIN_MAG=50, frame of all mags below 50 -> no source beats; FSM back to IDLE after 1 cycle.
- Second sop after 3 beats of a frame -> frame_error for 1 cycle; output reflects only the second frame.
- Reset asserted during EMIT after 2 beats -> outputs 0 in the same cycle; no eop emitted; the next frame is processed normally.
- Valid beat with sop=0 in IDLE -> frame_error pulse; no output.
